seq3_scan_ctrl: RTL
===================

# seq3_scan_ctrl

Sequencing controller for the 3-consecutive-ones detector. It accepts a W-bit word over a valid/ready handshake and slides a 4-bit window across it, one position per clock. Each window is checked with the same rule as the combinational detector: hit when window[3:1] or window[2:0] is all ones. The block accumulates the hit count and the first hit position, then presents them on a valid/ready result port.

## Interface
- W, 16, input word width; W ≥ 4; number of windows N = W-3
- CNT_W, 4, width of hit_cnt; must satisfy N ≤ 2^CNT_W − 1
- POS_W, 4, width of first_pos; must satisfy W-4 ≤ 2^POS_W − 1
- clk  in  1  clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data valid
- in_ready  out  1  controller can accept a word
- in_data  in  W  word to scan
- abort  in  1  synchronous abort, returns to IDLE
- busy  out  1  high in SCAN
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- found  out  1  at least one window hit
- hit_cnt  out  CNT_W  number of hitting windows
- first_pos  out  POS_W  lowest window index p that hit; 0 if found=0

## Operation
- Window p (0 ≤ p ≤ W-4) is word[p+3:p].
- hit(p) = (win[3]&win[2]&win[1]) | (win[2]&win[1]&win[0]).
- FSM states: IDLE, SCAN, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready:
    - capture in_data into the word register
    - pos←0, hit_cnt←0, found←0, first_pos←0
    - go to SCAN
  - SCAN: in_ready=0, busy=1. Each cycle, evaluate hit(pos) on the captured word:
    - If hit: hit_cnt←hit_cnt+1.
    - If hit & !found: first_pos←pos, found←1.
    - If pos==W-4: go to DONE; otherwise pos←pos+1.
  - DONE: out_valid=1. found, hit_cnt and first_pos are held stable until out_ready=1. On out_valid & out_ready, go to IDLE.
- Results stay on the ports after the handshake until the next accept clears them.
- in_data changes after the accept do not affect the scan.
- abort=1 in SCAN or DONE: go to IDLE at the next edge. The result is discarded and out_valid drops. abort takes priority over the out_ready handshake and over the last SCAN step. abort in IDLE has no effect.
- hit_cnt never wraps, given the parameter constraint.

## Timing
- Reset (rst_b=0, asynchronous):
  - state=IDLE, pos=0
  - in_ready=1, busy=0, out_valid=0
  - found=0, hit_cnt=0, first_pos=0
- Reset mid-SCAN or mid-DONE aborts immediately with no result. The first accept is possible on the first edge after rst_b rises.
- Accept occurs at edge E0. SCAN covers edges E1..EN, one window per edge (N=13 for W=16). out_valid rises after EN, so result latency is N cycles from accept.
- in_ready and busy are pure decodes of the state.
- Back-to-back operation: a DONE handshake at edge Ek makes in_ready=1 in the following cycle; the next accept is possible at Ek+1. Maximum throughput is one word per N+2 cycles.
- in_valid held while in_ready=0 is ignored, not queued.

## Test plan
- Reset, then accept 16'h0000 → out_valid 13 cycles after accept; found=0, hit_cnt=0, first_pos=0.
- Accept 16'h0E00 (bits 11:9 set) → hits at p=8 and p=9; found=1, hit_cnt=2, first_pos=8.
- Accept 16'hFFFF → found=1, hit_cnt=13, first_pos=0. Accept 16'hE000 → hit_cnt=1, first_pos=12. Accept 16'h5555 → hit_cnt=0.
- Hold out_ready=0 for 5 cycles in DONE → out_valid, found, hit_cnt and first_pos stable; in_ready=0. Raise out_ready → IDLE next cycle. An in_valid held high is accepted on the following edge.
- Accept 16'h0007 and change in_data to 16'hFFFF at E1 → result is hit_cnt=1, first_pos=0, from the captured word.
- Pulse abort at E5 of a scan → IDLE at the next edge and no out_valid. Separately, assert rst_b=0 mid-SCAN → all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/seq3_scan_ctrl_if.sv
// seq3_scan_ctrl_if: handshake and result bundle for seq3_scan_ctrl.
//   in_valid/in_ready/in_data : word input handshake
//   abort                     : synchronous scan abort
//   busy                      : controller is scanning
//   out_valid/out_ready       : result handshake
//   found/hit_cnt/first_pos   : scan result
// slave = controller side, master = producer/consumer side.
interface seq3_scan_ctrl_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned POS_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             abort;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic             found;
  logic [CNT_W-1:0] hit_cnt;
  logic [POS_W-1:0] first_pos;

  modport slave (
    input  in_valid, in_data, abort, out_ready,
    output in_ready, busy, out_valid, found, hit_cnt, first_pos
  );

  modport master (
    output in_valid, in_data, abort, out_ready,
    input  in_ready, busy, out_valid, found, hit_cnt, first_pos
  );
endinterface

// File: rtl/seq3_scan_ctrl.sv
// seq3_scan_ctrl: accepts a W-bit word, slides a 4-bit window across it one
// position per clock and reports whether any window holds three consecutive
// ones, how many windows hit, and the lowest hitting window index.
//   clk   : rising-edge clock
//   rst_b : asynchronous active-low reset
//   bus   : seq3_scan_ctrl_if.slave (input handshake, abort, busy,
//           result handshake and result fields)
module seq3_scan_ctrl #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned POS_W = 4
) (
  input logic            clk,
  input logic            rst_b,
  seq3_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     word_q, word_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             found_q, found_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] first_q, first_d;

  logic [3:0] win;
  logic       hit;
  logic       last;

  always_comb begin
    win  = 4'(word_q >> pos_q);
    hit  = (&win[3:1]) | (&win[2:0]);
    last = (pos_q == POS_W'(W - 4));

    state_d = state_q;
    word_d  = word_q;
    pos_d   = pos_q;
    found_d = found_q;
    cnt_d   = cnt_q;
    first_d = first_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          pos_d   = '0;
          found_d = 1'b0;
          cnt_d   = '0;
          first_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // abort wins over the scan step, including the final window
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          if (hit) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (hit && !found_q) begin
            found_d = 1'b1;
            first_d = pos_q;
          end
          if (last) begin
            state_d = DONE;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.abort || bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      word_q  <= '0;
      pos_q   <= '0;
      found_q <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pos_q   <= pos_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q == SCAN);
    bus.out_valid = (state_q == DONE);
    bus.found     = found_q;
    bus.hit_cnt   = cnt_q;
    bus.first_pos = first_q;
  end

endmodule
